// File: rtl/alu_sequencer.sv
// Multi-cycle control sequencer for the 8-bit ALU: decodes 9-bit instructions,
// owns the flag/overflow status registers, steers write-back and runs the LW/SW handshake.
module alu_sequencer #(
   parameter int unsigned MEM_TIMEOUT = 16
) (
   input  logic       CLK,
   input  logic       RESET_N,
   input  logic [8:0] INSTR,
   input  logic       INSTR_VALID,
   output logic       INSTR_READY,
   output logic [2:0] ALU_OP,
   output logic [2:0] ALU_FUNC,
   output logic       ALU_FLAG_IN,
   output logic       ALU_OVF_IN,
   input  logic [7:0] ALU_RESULT,
   input  logic       ALU_FLAG_OUT,
   input  logic       ALU_OVF_OUT,
   output logic [2:0] RF_RA,
   output logic [2:0] RF_RB,
   output logic       RF_WE,
   output logic [7:0] RF_WDATA,
   output logic       MEM_REQ,
   output logic       MEM_WE,
   output logic [7:0] MEM_ADDR,
   input  logic       MEM_ACK,
   input  logic [7:0] MEM_RDATA,
   output logic       DONE,
   output logic       ERR,
   output logic [1:0] STATE_DBG
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_MEM  = 2'd2
   } state_t;

   localparam logic [2:0] OP_LW  = 3'd0;
   localparam logic [2:0] OP_SW  = 3'd1;
   localparam logic [2:0] OP_ADD = 3'd2;
   localparam logic [2:0] OP_SUB = 3'd3;
   localparam logic [2:0] OP_CEQ = 3'd4;
   localparam logic [2:0] OP_CLT = 3'd5;
   localparam logic [2:0] OP_SEI = 3'd6;
   localparam logic [2:0] OP_OTY = 3'd7;

   // Last wait-counter value before the request is abandoned.
   localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

   state_t     state_q, state_d;
   logic [8:0] instr_q, instr_d;
   logic       flag_q, flag_d;
   logic       ovf_q, ovf_d;
   logic       err_q, err_d;
   logic [7:0] mem_addr_q, mem_addr_d;
   logic       mem_we_q, mem_we_d;
   logic [7:0] wait_cnt_q, wait_cnt_d;
   logic       out_en_q;

   logic       ready;
   logic       rf_we;
   logic [7:0] rf_wdata;
   logic       done;
   logic       mem_req;
   logic [2:0] op;

   assign op = instr_q[8:6];

   // Handshake: an instruction transfers on a rising edge where INSTR_VALID and
   // INSTR_READY are both high; READY is only high in IDLE, VALID may be held.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q    <= S_IDLE;
         instr_q    <= 9'd0;
         flag_q     <= 1'b0;
         ovf_q      <= 1'b0;
         err_q      <= 1'b0;
         mem_addr_q <= 8'd0;
         mem_we_q   <= 1'b0;
         wait_cnt_q <= 8'd0;
         out_en_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         instr_q    <= instr_d;
         flag_q     <= flag_d;
         ovf_q      <= ovf_d;
         err_q      <= err_d;
         mem_addr_q <= mem_addr_d;
         mem_we_q   <= mem_we_d;
         wait_cnt_q <= wait_cnt_d;
         out_en_q   <= 1'b1;
      end
   end

   always_comb begin
      state_d    = state_q;
      instr_d    = instr_q;
      flag_d     = flag_q;
      ovf_d      = ovf_q;
      err_d      = err_q;
      mem_addr_d = mem_addr_q;
      mem_we_d   = mem_we_q;
      wait_cnt_d = wait_cnt_q;
      ready      = 1'b0;
      rf_we      = 1'b0;
      rf_wdata   = 8'd0;
      done       = 1'b0;
      mem_req    = 1'b0;

      case (state_q)
         S_IDLE: begin
            ready = out_en_q;
            if (INSTR_VALID && out_en_q) begin
               instr_d = INSTR;
               state_d = S_EXEC;
            end
         end

         S_EXEC: begin
            case (op)
               OP_ADD, OP_SUB, OP_OTY: begin
                  rf_we    = 1'b1;
                  rf_wdata = ALU_RESULT;
                  ovf_d    = ALU_OVF_OUT;
                  done     = 1'b1;
                  state_d  = S_IDLE;
               end
               OP_SEI: begin
                  rf_we    = 1'b1;
                  rf_wdata = ALU_RESULT;
                  done     = 1'b1;
                  state_d  = S_IDLE;
               end
               OP_CEQ, OP_CLT: begin
                  flag_d  = ALU_FLAG_OUT;
                  ovf_d   = 1'b0;
                  done    = 1'b1;
                  state_d = S_IDLE;
               end
               default: begin
                  // LW/SW: the ALU computed the address this cycle; hold it for the request.
                  mem_addr_d = ALU_RESULT;
                  mem_we_d   = (op == OP_SW);
                  wait_cnt_d = 8'd0;
                  state_d    = S_MEM;
               end
            endcase
         end

         S_MEM: begin
            mem_req = 1'b1;
            if (MEM_ACK) begin
               if (!mem_we_q) begin
                  rf_we    = 1'b1;
                  rf_wdata = MEM_RDATA;
               end
               done    = 1'b1;
               state_d = S_IDLE;
            end else if (wait_cnt_q == TIMEOUT_LAST) begin
               err_d   = 1'b1;
               done    = 1'b1;
               state_d = S_IDLE;
            end else begin
               wait_cnt_d = wait_cnt_q + 8'd1;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   assign INSTR_READY = ready;
   assign ALU_OP      = instr_q[8:6];
   assign ALU_FUNC    = instr_q[2:0];
   assign RF_RA       = instr_q[5:3];
   assign RF_RB       = instr_q[2:0];
   assign ALU_FLAG_IN = flag_q;
   assign ALU_OVF_IN  = ovf_q;
   assign RF_WE       = rf_we;
   assign RF_WDATA    = rf_wdata;
   assign MEM_REQ     = mem_req;
   assign MEM_WE      = mem_we_q & mem_req;
   assign MEM_ADDR    = mem_addr_q;
   assign DONE        = done;
   assign ERR         = err_q;
   assign STATE_DBG   = state_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: the bench plays ALU and data memory,
// checking hand-computed outputs cycle by cycle with immediate assertions.
module tb_alu_sequencer;

   logic       CLK;
   logic       RESET_N;
   logic [8:0] INSTR;
   logic       INSTR_VALID;
   logic       INSTR_READY;
   logic [2:0] ALU_OP;
   logic [2:0] ALU_FUNC;
   logic       ALU_FLAG_IN;
   logic       ALU_OVF_IN;
   logic [7:0] ALU_RESULT;
   logic       ALU_FLAG_OUT;
   logic       ALU_OVF_OUT;
   logic [2:0] RF_RA;
   logic [2:0] RF_RB;
   logic       RF_WE;
   logic [7:0] RF_WDATA;
   logic       MEM_REQ;
   logic       MEM_WE;
   logic [7:0] MEM_ADDR;
   logic       MEM_ACK;
   logic [7:0] MEM_RDATA;
   logic       DONE;
   logic       ERR;
   logic [1:0] STATE_DBG;

   int tests;
   int fails;

   alu_sequencer #(.MEM_TIMEOUT(4)) dut (
      .CLK(CLK), .RESET_N(RESET_N),
      .INSTR(INSTR), .INSTR_VALID(INSTR_VALID), .INSTR_READY(INSTR_READY),
      .ALU_OP(ALU_OP), .ALU_FUNC(ALU_FUNC),
      .ALU_FLAG_IN(ALU_FLAG_IN), .ALU_OVF_IN(ALU_OVF_IN),
      .ALU_RESULT(ALU_RESULT), .ALU_FLAG_OUT(ALU_FLAG_OUT), .ALU_OVF_OUT(ALU_OVF_OUT),
      .RF_RA(RF_RA), .RF_RB(RF_RB), .RF_WE(RF_WE), .RF_WDATA(RF_WDATA),
      .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR),
      .MEM_ACK(MEM_ACK), .MEM_RDATA(MEM_RDATA),
      .DONE(DONE), .ERR(ERR), .STATE_DBG(STATE_DBG)
   );

   // Clock / reset
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #2;
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk3(input string tag, input logic [2:0] obs, input logic [2:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      tests        = 0;
      fails        = 0;
      RESET_N      = 1'b0;
      INSTR        = 9'd0;
      INSTR_VALID  = 1'b0;
      ALU_RESULT   = 8'd0;
      ALU_FLAG_OUT = 1'b0;
      ALU_OVF_OUT  = 1'b0;
      MEM_ACK      = 1'b0;
      MEM_RDATA    = 8'd0;

      // Reset state
      tick();
      tick();
      #1;
      chk1("rst_ready", INSTR_READY, 1'b0);
      chk1("rst_req", MEM_REQ, 1'b0);
      chk1("rst_we", RF_WE, 1'b0);
      chk1("rst_done", DONE, 1'b0);
      chk1("rst_err", ERR, 1'b0);
      chk3("rst_op", ALU_OP, 3'd0);
      RESET_N = 1'b1;
      #1;
      chk1("rel_ready_same_cycle", INSTR_READY, 1'b0);

      // ADD writes back and captures overflow
      tick();
      INSTR = 9'b010_001_010; INSTR_VALID = 1'b1;
      #1;
      chk1("add_ready", INSTR_READY, 1'b1);
      tick();
      INSTR_VALID = 1'b0; ALU_RESULT = 8'h10; ALU_OVF_OUT = 1'b1;
      #1;
      chk1("add_we", RF_WE, 1'b1);
      chk3("add_ra", RF_RA, 3'd1);
      chk3("add_rb", RF_RB, 3'd2);
      chk3("add_op", ALU_OP, 3'd2);
      chk8("add_wdata", RF_WDATA, 8'h10);
      chk1("add_done", DONE, 1'b1);
      chk1("add_ready_busy", INSTR_READY, 1'b0);
      chk1("add_ovf_in_old", ALU_OVF_IN, 1'b0);

      // SEI leaves status untouched
      tick();
      ALU_OVF_OUT = 1'b0; INSTR = 9'b110_000_101; INSTR_VALID = 1'b1;
      #1;
      chk1("ovf_in_after_add", ALU_OVF_IN, 1'b1);
      chk1("idle_done", DONE, 1'b0);
      chk1("idle_we", RF_WE, 1'b0);
      tick();
      INSTR_VALID = 1'b0; ALU_RESULT = 8'h05;
      #1;
      chk1("sei_we", RF_WE, 1'b1);
      chk8("sei_wdata", RF_WDATA, 8'h05);
      chk3("sei_func", ALU_FUNC, 3'd5);
      chk1("sei_ovf_kept", ALU_OVF_IN, 1'b1);

      // CEQ sets flag, clears overflow, no write
      tick();
      INSTR = 9'b100_011_100; INSTR_VALID = 1'b1;
      #1;
      chk1("sei_ovf_still", ALU_OVF_IN, 1'b1);
      tick();
      INSTR_VALID = 1'b0; ALU_FLAG_OUT = 1'b1; ALU_OVF_OUT = 1'b1;
      #1;
      chk1("ceq_we", RF_WE, 1'b0);
      chk1("ceq_done", DONE, 1'b1);
      chk1("ceq_flag_old", ALU_FLAG_IN, 1'b0);

      // O-type follows: sees flag=1, ovf=0
      tick();
      ALU_FLAG_OUT = 1'b0; ALU_OVF_OUT = 1'b0;
      INSTR = 9'b111_010_011; INSTR_VALID = 1'b1;
      #1;
      chk1("ceq_flag_new", ALU_FLAG_IN, 1'b1);
      chk1("ceq_ovf_clr", ALU_OVF_IN, 1'b0);
      tick();
      INSTR_VALID = 1'b0; ALU_RESULT = 8'hA5;
      #1;
      chk3("oty_func", ALU_FUNC, 3'd3);
      chk1("oty_we", RF_WE, 1'b1);
      chk8("oty_wdata", RF_WDATA, 8'hA5);
      chk3("oty_ra", RF_RA, 3'd2);

      // LW, ACK on third MEM cycle
      tick();
      INSTR = 9'b000_100_001; INSTR_VALID = 1'b1;
      #1;
      chk1("lw_accept_ready", INSTR_READY, 1'b1);
      tick();
      INSTR_VALID = 1'b0; ALU_RESULT = 8'h2A;
      #1;
      chk1("lw_exec_we", RF_WE, 1'b0);
      chk1("lw_exec_done", DONE, 1'b0);
      chk1("lw_exec_req", MEM_REQ, 1'b0);
      tick();
      ALU_RESULT = 8'h00;
      #1;
      chk1("lw_m1_req", MEM_REQ, 1'b1);
      chk8("lw_m1_addr", MEM_ADDR, 8'h2A);
      chk1("lw_m1_mwe", MEM_WE, 1'b0);
      chk1("lw_m1_we", RF_WE, 1'b0);
      chk1("lw_m1_done", DONE, 1'b0);
      tick();
      #1;
      chk1("lw_m2_req", MEM_REQ, 1'b1);
      chk1("lw_m2_done", DONE, 1'b0);
      tick();
      MEM_ACK = 1'b1; MEM_RDATA = 8'h5C;
      #1;
      chk1("lw_m3_req", MEM_REQ, 1'b1);
      chk1("lw_ack_we", RF_WE, 1'b1);
      chk8("lw_ack_wdata", RF_WDATA, 8'h5C);
      chk3("lw_ack_ra", RF_RA, 3'd4);
      chk1("lw_ack_done", DONE, 1'b1);

      // SW with no ACK times out after 4 request cycles
      tick();
      MEM_ACK = 1'b0; INSTR = 9'b001_101_110; INSTR_VALID = 1'b1;
      #1;
      chk1("lw_after_req", MEM_REQ, 1'b0);
      chk1("lw_after_done", DONE, 1'b0);
      chk1("lw_after_err", ERR, 1'b0);
      chk1("sw_accept_ready", INSTR_READY, 1'b1);
      tick();
      INSTR_VALID = 1'b0; ALU_RESULT = 8'h77;
      #1;
      chk1("sw_exec_req", MEM_REQ, 1'b0);
      for (int i = 0; i < 4; i++) begin
         tick();
         #1;
         chk1("sw_req", MEM_REQ, 1'b1);
         chk1("sw_mwe", MEM_WE, 1'b1);
         chk8("sw_addr", MEM_ADDR, 8'h77);
         chk3("sw_rb", RF_RB, 3'd6);
         chk1("sw_we", RF_WE, 1'b0);
         chk1("sw_done", DONE, i == 3);
         chk1("sw_err_pending", ERR, 1'b0);
      end
      tick();
      #1;
      chk1("sw_to_req_drop", MEM_REQ, 1'b0);
      chk1("sw_to_err", ERR, 1'b1);
      chk1("sw_to_ready", INSTR_READY, 1'b1);

      // Back-pressure: VALID held with SUB ops
      INSTR = 9'b011_001_001; INSTR_VALID = 1'b1; ALU_RESULT = 8'h33;
      for (int i = 0; i < 6; i++) begin
         if (i > 0) tick();
         #1;
         chk1("bp_ready", INSTR_READY, (i % 2) == 0);
         chk1("bp_done", DONE, (i % 2) == 1);
         chk1("bp_we", RF_WE, (i % 2) == 1);
         chk1("bp_err_sticky", ERR, 1'b1);
      end

      // LW with ACK arriving in the timeout cycle: ACK wins
      INSTR = 9'b000_111_000;
      tick();
      #1;
      chk1("lwto_accept_ready", INSTR_READY, 1'b1);
      tick();
      INSTR_VALID = 1'b0; ALU_RESULT = 8'h80;
      #1;
      for (int i = 0; i < 3; i++) begin
         tick();
         #1;
         chk1("lwto_req", MEM_REQ, 1'b1);
         chk1("lwto_we_wait", RF_WE, 1'b0);
         chk1("lwto_done_wait", DONE, 1'b0);
      end
      tick();
      MEM_ACK = 1'b1; MEM_RDATA = 8'hE1;
      #1;
      chk1("lwto_req4", MEM_REQ, 1'b1);
      chk1("lwto_ack_we", RF_WE, 1'b1);
      chk8("lwto_ack_wdata", RF_WDATA, 8'hE1);
      chk1("lwto_ack_done", DONE, 1'b1);
      tick();
      MEM_ACK = 1'b0;
      #1;
      chk1("lwto_req_drop", MEM_REQ, 1'b0);
      chk1("lwto_err_sticky", ERR, 1'b1);

      // Reset asserted mid-MEM
      INSTR = 9'b001_000_000; INSTR_VALID = 1'b1;
      tick();
      INSTR_VALID = 1'b0; ALU_RESULT = 8'h44;
      tick();
      #1;
      chk1("mr_req_before", MEM_REQ, 1'b1);
      chk1("mr_flag_before", ALU_FLAG_IN, 1'b1);
      RESET_N = 1'b0;
      #1;
      chk1("mr_req_async", MEM_REQ, 1'b0);
      chk1("mr_we", RF_WE, 1'b0);
      chk1("mr_err", ERR, 1'b0);
      chk1("mr_flag", ALU_FLAG_IN, 1'b0);
      chk1("mr_ovf", ALU_OVF_IN, 1'b0);
      chk1("mr_ready", INSTR_READY, 1'b0);
      chk8("mr_addr", MEM_ADDR, 8'h00);
      tick();
      RESET_N = 1'b1;
      #1;
      chk1("mr_rel_ready_same", INSTR_READY, 1'b0);
      tick();
      #1;
      chk1("mr_rel_ready_next", INSTR_READY, 1'b1);
      chk1("mr_rel_done", DONE, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
